// File: rtl/dmem_ctrl.sv
// Single-port data memory behind a valid/ready request/response pair, with byte strobes,
// configurable wait states and an error flag for misaligned or out-of-range accesses.
module dmem_ctrl #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
  parameter int unsigned       LATENCY   = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_we,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [DATA_W-1:0]   i_req_wdata,
  input  logic [DATA_W/8-1:0] i_req_wstrb,
  output logic                o_resp_valid,
  input  logic                i_resp_ready,
  output logic [DATA_W-1:0]   o_resp_rdata,
  output logic                o_resp_err
);

  localparam int unsigned B  = DATA_W / 8;
  localparam int unsigned LB = $clog2(B);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_we, r_err;
  logic [IW-1:0]     r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic [B-1:0]      r_wstrb;
  logic [DATA_W-1:0] r_rdata;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] w_off, w_word;
  logic              w_err_in, w_accept, w_enter_resp;
  logic              w_a_we, w_a_err;
  logic [IW-1:0]     w_a_idx;
  logic [DATA_W-1:0] w_a_wdata;
  logic [B-1:0]      w_a_wstrb;

  assign w_off    = i_req_addr - BASE_ADDR;
  assign w_word   = w_off >> LB;
  assign w_err_in = (i_req_addr < BASE_ADDR) || (w_word >= ADDR_W'(DEPTH)) ||
                    ((i_req_addr & ADDR_W'(B - 1)) != '0);

  assign o_req_ready  = (r_state == StIdle);
  assign o_resp_valid = (r_state == StResp);
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_resp_err;
  assign w_accept     = i_req_valid && o_req_ready;

  // With zero wait states the access happens on the acceptance edge, so use the live inputs.
  assign w_a_we    = (r_state == StIdle) ? i_req_we    : r_we;
  assign w_a_err   = (r_state == StIdle) ? w_err_in    : r_err;
  assign w_a_idx   = (r_state == StIdle) ? w_word[IW-1:0] : r_idx;
  assign w_a_wdata = (r_state == StIdle) ? i_req_wdata : r_wdata;
  assign w_a_wstrb = (r_state == StIdle) ? i_req_wstrb : r_wstrb;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_nxt  = StResp;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = StWait;
            w_cnt_nxt   = CW'(LATENCY - 2);
          end
        end
      end
      StWait: begin
        if (r_cnt == '0) begin
          w_state_nxt  = StResp;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      StResp: begin
        if (i_resp_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_rdata    <= '0;
      r_resp_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we    <= i_req_we;
        r_err   <= w_err_in;
        r_idx   <= w_word[IW-1:0];
        r_wdata <= i_req_wdata;
        r_wstrb <= i_req_wstrb;
      end
      if (w_enter_resp) begin
        r_rdata    <= (!w_a_we && !w_a_err) ? r_mem[w_a_idx] : '0;
        r_resp_err <= w_a_err;
      end
    end
  end

  // Array is deliberately not reset; a write commits only on the edge entering the response.
  always_ff @(posedge i_clk) begin
    if (w_enter_resp && w_a_we && !w_a_err) begin
      for (int i = 0; i < int'(B); i++) begin
        if (w_a_wstrb[i]) r_mem[w_a_idx][8*i +: 8] <= w_a_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: one zero-wait-state and one four-cycle instance, checked against a
// per-byte memory model built from the address/error rules.
module tb_dmem_ctrl;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic             clk = 1'b0;
  logic [1:0]       rstn, vld, rr, rv, re;
  logic             we, resp_ready;
  logic [31:0]      addr, wdata;
  logic [3:0]       wstrb;
  logic [1:0][31:0] rd;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] mdl [2][1024];
  logic [3:0]  kb  [2][1024];

  always #5 clk = ~clk;

  dmem_ctrl #(.LATENCY(1)) u_l1 (
    .i_clk(clk), .i_rst_n(rstn[0]), .i_req_valid(vld[0]), .o_req_ready(rr[0]),
    .i_req_we(we), .i_req_addr(addr), .i_req_wdata(wdata), .i_req_wstrb(wstrb),
    .o_resp_valid(rv[0]), .i_resp_ready(resp_ready), .o_resp_rdata(rd[0]), .o_resp_err(re[0])
  );

  dmem_ctrl #(.LATENCY(4)) u_l4 (
    .i_clk(clk), .i_rst_n(rstn[1]), .i_req_valid(vld[1]), .o_req_ready(rr[1]),
    .i_req_we(we), .i_req_addr(addr), .i_req_wdata(wdata), .i_req_wstrb(wstrb),
    .o_resp_valid(rv[1]), .i_resp_ready(resp_ready), .o_resp_rdata(rd[1]), .o_resp_err(re[1])
  );

  // Reference: expected response of an access, updating the model on legal writes.
  task automatic model_acc(input int s, input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] st, output logic [31:0] erd, output logic eerr,
                           output bit eknown);
    int widx;
    eerr   = (a < BASE) || ((a - BASE) / 4 >= 1024) || (a % 4 != 0);
    erd    = '0;
    eknown = 1'b1;
    if (!eerr) begin
      widx = int'((a - BASE) / 4);
      if (w) begin
        for (int i = 0; i < 4; i++) begin
          if (st[i]) begin
            mdl[s][widx][8*i +: 8] = wd[8*i +: 8];
            kb[s][widx][i] = 1'b1;
          end
        end
      end else begin
        erd    = mdl[s][widx];
        eknown = (kb[s][widx] == 4'hF);
      end
    end
  endtask

  task automatic txn(input int s, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input int hold, output bit acc, output int lat,
                     output logic [31:0] rdata, output logic err, output bit hold_ok,
                     output bit idle_after);
    we = w; addr = a; wdata = wd; wstrb = st;
    vld[s] = 1'b1;
    acc = (rr[s] === 1'b1);
    @(posedge clk); #1;
    vld[s] = 1'b0;
    lat = 1;
    while (rv[s] !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = rd[s];
    err = re[s];
    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (rv[s] !== 1'b1 || rr[s] !== 1'b0 || rd[s] !== rdata || re[s] !== err) hold_ok = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    idle_after = (rr[s] === 1'b1) && (rv[s] === 1'b0);
  endtask

  task automatic test_reset();
    rstn = 2'b00; vld = 2'b00; resp_ready = 1'b0;
    we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 2'b11;
    for (int s = 0; s < 2; s++) begin
      n_total++;
      if (rr[s] !== 1'b1) begin n_bad++; $display("FAIL reset_ready[%0d]: got %b want 1", s, rr[s]); end
      n_total++;
      if (rv[s] !== 1'b0) begin n_bad++; $display("FAIL reset_valid[%0d]: got %b want 0", s, rv[s]); end
      n_total++;
      if (re[s] !== 1'b0) begin n_bad++; $display("FAIL reset_err[%0d]: got %b want 0", s, re[s]); end
      n_total++;
      if (rd[s] !== 32'h0) begin n_bad++; $display("FAIL reset_rdata[%0d]: got %h want 0", s, rd[s]); end
    end
  endtask

  task automatic test_l1_roundtrip();
    bit acc, hok, idl, ek; int lat; logic [31:0] got, erd; logic ger, eer;
    model_acc(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, erd, eer, ek);
    txn(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, acc, lat, got, ger, hok, idl);
    n_total++;
    if (!acc || lat != 1) begin n_bad++; $display("FAIL l1_wr_lat: acc %0d lat %0d want 1", acc, lat); end
    n_total++;
    if (ger !== 1'b0 || got !== 32'h0) begin
      n_bad++; $display("FAIL l1_wr_resp: err %b data %h want 0 0", ger, got);
    end
    model_acc(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, erd, eer, ek);
    txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, acc, lat, got, ger, hok, idl);
    n_total++;
    if (got !== 32'hDEAD_BEEF || ger !== 1'b0) begin
      n_bad++; $display("FAIL l1_rd: got %h err %b want deadbeef 0", got, ger);
    end
  endtask

  task automatic test_strobes();
    bit acc, hok, idl, ek; int lat; logic [31:0] got, erd; logic ger, eer;
    model_acc(0, 1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, erd, eer, ek);
    txn(0, 1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, 0, acc, lat, got, ger, hok, idl);
    model_acc(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, erd, eer, ek);
    txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, acc, lat, got, ger, hok, idl);
    n_total++;
    if (got !== 32'hDE22_BE44) begin n_bad++; $display("FAIL strobe_rd: got %h want de22be44", got); end
    n_total++;
    if (got !== erd) begin n_bad++; $display("FAIL strobe_model: got %h want %h", got, erd); end
  endtask

  task automatic test_backpressure();
    bit acc, hok, idl, ek; int lat; logic [31:0] got, erd; logic ger, eer;
    model_acc(1, 1'b1, 32'h8000_0010, 32'hA5A5_0F0F, 4'hF, erd, eer, ek);
    txn(1, 1'b1, 32'h8000_0010, 32'hA5A5_0F0F, 4'hF, 0, acc, lat, got, ger, hok, idl);
    n_total++;
    if (lat != 4) begin n_bad++; $display("FAIL l4_wr_lat: got %0d want 4", lat); end
    model_acc(1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, erd, eer, ek);
    txn(1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 5, acc, lat, got, ger, hok, idl);
    n_total++;
    if (!acc || lat != 4) begin n_bad++; $display("FAIL l4_rd_lat: acc %0d lat %0d want 4", acc, lat); end
    n_total++;
    if (got !== 32'hA5A5_0F0F) begin n_bad++; $display("FAIL l4_rd: got %h want a5a50f0f", got); end
    n_total++;
    if (!hok) begin n_bad++; $display("FAIL l4_hold: response changed or ready rose while held"); end
    n_total++;
    if (!idl) begin n_bad++; $display("FAIL l4_idle: got not-idle want idle after handshake"); end
  endtask

  task automatic test_errors();
    bit acc, hok, idl, ek; int lat; logic [31:0] got, erd; logic ger, eer;
    logic [31:0] bad [3];
    bad[0] = 32'h8000_0012; bad[1] = 32'h8000_1000; bad[2] = 32'h7FFF_FFFC;
    model_acc(0, 1'b1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, erd, eer, ek);
    txn(0, 1'b1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 0, acc, lat, got, ger, hok, idl);
    model_acc(0, 1'b1, 32'h8000_0FFC, 32'h600D_CAFE, 4'hF, erd, eer, ek);
    txn(0, 1'b1, 32'h8000_0FFC, 32'h600D_CAFE, 4'hF, 0, acc, lat, got, ger, hok, idl);
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 2; w++) begin
        model_acc(0, 1'(w), bad[k], 32'hFFFF_FFFF, 4'hF, erd, eer, ek);
        txn(0, 1'(w), bad[k], 32'hFFFF_FFFF, 4'hF, 0, acc, lat, got, ger, hok, idl);
        n_total++;
        if (ger !== 1'b1 || got !== 32'h0) begin
          n_bad++; $display("FAIL err_%h_we%0d: err %b data %h want 1 0", bad[k], w, ger, got);
        end
      end
    end
    txn(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, acc, lat, got, ger, hok, idl);
    n_total++;
    if (got !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL err_word0: got %h want 0badf00d", got); end
    txn(0, 1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 0, acc, lat, got, ger, hok, idl);
    n_total++;
    if (got !== 32'h600D_CAFE || ger !== 1'b0) begin
      n_bad++; $display("FAIL err_word1023: got %h err %b want 600dcafe 0", got, ger);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit acc, hok, idl, ek; int lat, seen; logic [31:0] got, erd; logic ger, eer;
    model_acc(1, 1'b1, 32'h8000_0020, 32'h1234_5678, 4'hF, erd, eer, ek);
    txn(1, 1'b1, 32'h8000_0020, 32'h1234_5678, 4'hF, 0, acc, lat, got, ger, hok, idl);
    we = 1'b1; addr = 32'h8000_0020; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    vld[1] = 1'b1;
    @(posedge clk); #1;
    vld[1] = 1'b0;
    @(posedge clk); #1;
    rstn[1] = 1'b0;
    @(posedge clk); #1;
    rstn[1] = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (rv[1] === 1'b1) seen++;
      @(posedge clk); #1;
    end
    n_total++;
    if (seen != 0) begin n_bad++; $display("FAIL rst_wait_resp: got %0d responses want 0", seen); end
    model_acc(1, 1'b0, 32'h8000_0020, 32'h0, 4'h0, erd, eer, ek);
    txn(1, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, acc, lat, got, ger, hok, idl);
    n_total++;
    if (got !== 32'h1234_5678) begin n_bad++; $display("FAIL rst_wait_rd: got %h want 12345678", got); end
  endtask

  task automatic test_random();
    bit acc, hok, idl, ek; int lat, s; logic [31:0] got, erd, a; logic ger, eer, w;
    logic [3:0] st;
    for (int n = 0; n < 80; n++) begin
      s = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      st = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
        0: a = BASE + 32'h1000 + 32'($urandom_range(0, 7)) * 4;
        1: a = BASE + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
        2: a = BASE - 32'($urandom_range(1, 8)) * 4;
        default: a = BASE + 32'($urandom_range(0, 15)) * 4;
      endcase
      wdata = $urandom;
      model_acc(s, w, a, wdata, st, erd, eer, ek);
      txn(s, w, a, wdata, st, 0, acc, lat, got, ger, hok, idl);
      n_total++;
      if (!acc || lat != (s == 1 ? 4 : 1) || !idl) begin
        n_bad++; $display("FAIL rnd_timing[%0d]: acc %0d lat %0d idle %0d", n, acc, lat, idl);
      end
      n_total++;
      if (ger !== eer || (ek && got !== erd)) begin
        n_bad++;
        $display("FAIL rnd_resp[%0d] a=%h we=%b: got %h/%b want %h/%b", n, a, w, got, ger, erd, eer);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 1024; i++) begin
        kb[s][i] = 4'h0;
        mdl[s][i] = '0;
      end
    end
    test_reset();
    test_l1_roundtrip();
    test_strobes();
    test_backpressure();
    test_errors();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised single-port data memory with valid/ready request and response channels, per-byte write strobes and configurable access latency (wait states). It replaces the fixed 32-bit, zero-latency, mask-based data memory and sits behind the CPU load/store unit. It has one outstanding request and flags misaligned or out-of-range accesses through an error bit instead of aliasing. The storage is an on-chip array, so no DPI calls are involved.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8 and at least 8.
ADDR_W, 32, byte-address width.
DEPTH, 1024, number of words.
BASE_ADDR, 32'h8000_0000, byte address of word 0.
LATENCY, 1, cycles from request acceptance to response; must be at least 1.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  write data.
req_wstrb  in  DATA_W/8  byte enables; bit i covers bits [8i+7:8i].
resp_valid  out  1  response present.
resp_ready  in  1  consumer accepts response.
resp_rdata  out  DATA_W  read data; 0 for writes and errors.
resp_err  out  1  misaligned or out-of-range access.

Behaviour:
- Define B = DATA_W/8 and LB = log2(B). The word index is idx = (req_addr - BASE_ADDR) >> LB.
- An access is misaligned if req_addr[LB-1:0] != 0. It is out of range if req_addr < BASE_ADDR or idx >= DEPTH. Either condition sets err.
- States are IDLE, WAIT and RESP. req_ready = (state == IDLE). resp_valid = (state == RESP).
- Reset (rst_n low, asynchronous):
  - state goes to IDLE and the wait counter is cleared.
  - resp_rdata = 0 and resp_err = 0. resp_valid = 0 and req_ready = 1 once in IDLE.
  - Array contents are not reset.
- IDLE: on the edge where req_valid && req_ready, capture we, idx, wdata, wstrb and err.
  - If LATENCY == 1, go to RESP.
  - Otherwise go to WAIT with cnt = LATENCY-2.
- WAIT: if cnt == 0, go to RESP; else decrement cnt. Request inputs are ignored.
- On the edge entering RESP the access is performed:
  - Read, no error: resp_rdata = mem[idx] (the old contents), resp_err = 0.
  - Write, no error: for each byte i with wstrb[i] = 1, mem[idx] byte i is replaced by the wdata byte. Other bytes are unchanged. resp_rdata = 0.
  - Error: no array access, resp_rdata = 0, resp_err = 1.
  - wstrb = 0 on a write is legal: no change, no error.
- Response timing: resp_valid rises exactly LATENCY cycles after the acceptance edge.
- RESP:
  - resp_rdata and resp_err are held stable while resp_ready = 0.
  - When resp_ready = 1, go to IDLE.
  - req_ready stays 0 in RESP, so no request is accepted in the same cycle as a response handshake.
- Throughput is one request per LATENCY+1 cycles at best.
- Ordering: a read accepted after a completed write to the same word returns the written data. Writes commit before their response.
- Reset mid-operation: a request in WAIT is discarded and any pending write is not committed. A response held in RESP is dropped.
- Request inputs outside the acceptance edge are don't-care. The block does not need to check that they are stable.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, then high -> req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0.
- LATENCY = 1 round trip:
  - Write 0x8000_0010, wdata 0xDEADBEEF, wstrb 4'hF. resp_valid asserts the next cycle with resp_err = 0.
  - Then read 0x8000_0010 -> resp_rdata = 0xDEADBEEF.
- Byte strobes:
  - Write 0x11223344 with wstrb 4'b0101 onto 0xDEADBEEF at the same word.
  - Read back -> 0xDE22BE44.
- LATENCY = 4 with backpressure:
  - Read is accepted at cycle 0; resp_valid first seen at cycle 4.
  - Hold resp_ready = 0 for 5 cycles -> resp_rdata stable and req_ready = 0 throughout.
  - IDLE is reached one cycle after resp_ready = 1.
- Error cases, each giving resp_err = 1 and resp_rdata = 0:
  - Address 0x8000_0012 (misaligned).
  - Address 0x8000_1000 with DEPTH = 1024 (out of range).
  - Address 0x7FFF_FFFC (below base).
  - A write to the out-of-range address leaves all words unchanged, checked by reading back word 0 and word 1023.
- Reset mid-wait:
  - With LATENCY = 4, a write of 0xCAFEF00D to 0x8000_0020 is accepted.
  - rst_n pulses low two cycles later -> no response ever appears.
  - A later read of 0x8000_0020 returns the prior contents, not 0xCAFEF00D.
